// File: rtl/apb_timer_pkg.sv
// apb_timer shared definitions: register offsets, control/status bit positions, default ID.
// Pure constants, no logic; imported by apb_timer and apb_timer_prescaler.
package apb_timer_pkg;

    localparam logic [11:0] OFF_CTRL     = 12'h000;
    localparam logic [11:0] OFF_LOAD     = 12'h004;
    localparam logic [11:0] OFF_VALUE    = 12'h008;
    localparam logic [11:0] OFF_PRESCALE = 12'h00C;
    localparam logic [11:0] OFF_STATUS   = 12'h010;
    localparam logic [11:0] OFF_ID       = 12'h014;

    // Word index within the 32-byte register window, as latched from paddr[4:2].
    localparam logic [2:0] IDX_CTRL     = OFF_CTRL[4:2];
    localparam logic [2:0] IDX_LOAD     = OFF_LOAD[4:2];
    localparam logic [2:0] IDX_VALUE    = OFF_VALUE[4:2];
    localparam logic [2:0] IDX_PRESCALE = OFF_PRESCALE[4:2];
    localparam logic [2:0] IDX_STATUS   = OFF_STATUS[4:2];
    localparam logic [2:0] IDX_ID       = OFF_ID[4:2];

    localparam int CTRL_W        = 3;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STATUS_IF = 0;

    localparam logic [31:0] DEFAULT_ID = 32'h5449_4D52;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Purpose: divides hclk by (presc+1), emitting a one-cycle tick while enabled.
// Latency: tick is combinational from the count; clr zeroes the count at the next edge.
// Backpressure: none; counts every enabled cycle.
module apb_timer_prescaler
    import apb_timer_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt;

    assign tick = en && (pcnt == presc);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/apb_timer.sv
// Purpose: zero-wait APB 32-bit down-counting timer, prescaler, one-shot/periodic, level irq.
// Latency: prdata registered at end of setup; writes commit at end of access; irq one cycle after IF.
// Backpressure: none (no pready). Optional pslverr output when APB_TIMER_PSLVERR_EN is defined.
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ID_VALUE  = DEFAULT_ID,
    parameter int          PRESC_W   = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
`ifdef APB_TIMER_PSLVERR_EN
    ,
    output logic        pslverr
`endif
);

    logic               pend;
    logic [2:0]         idx_q;
    logic               wr_q;
    logic               hit_q;
    logic [31:0]        wdata_q;

    logic [CTRL_W-1:0]  ctrl;
    logic [31:0]        load;
    logic [31:0]        value;
    logic [PRESC_W-1:0] presc;
    logic               if_flag;

    logic               tick;
    logic               eff_tick;
    logic               expire;
    logic               presc_clr;
    logic [31:0]        rd_mux;

    // Address, data and direction are only valid in setup, so decode happens there.
    logic       setup;
    logic       access;
    logic       hit_now;
    logic [2:0] idx_now;
    logic       mapped_now;

    assign setup      = psel && !penable;
    assign access     = penable && pend;
    assign hit_now    = (paddr[31:12] == BASE_ADDR[31:12]) && (paddr[11:5] == 7'd0);
    assign idx_now    = paddr[4:2];
    assign mapped_now = (idx_now <= IDX_ID);

    logic unused_addr_bits;
    assign unused_addr_bits = ^paddr[1:0];

    logic wr_commit, wr_ctrl, wr_load, wr_presc, wr_status, en_rise;

    assign wr_commit = access && wr_q && hit_q;
    assign wr_ctrl   = wr_commit && (idx_q == IDX_CTRL);
    assign wr_load   = wr_commit && (idx_q == IDX_LOAD);
    assign wr_presc  = wr_commit && (idx_q == IDX_PRESCALE);
    assign wr_status = wr_commit && (idx_q == IDX_STATUS);
    assign en_rise   = wr_ctrl && wdata_q[CTRL_EN] && !ctrl[CTRL_EN];

    assign presc_clr = en_rise || wr_load;
    // A LOAD write in the same cycle discards the tick.
    assign eff_tick  = tick && !wr_load;
    assign expire    = eff_tick && (value == 32'd0);

    apb_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .hclk    (hclk),
        .hresetn (hresetn),
        .en      (ctrl[CTRL_EN]),
        .clr     (presc_clr),
        .presc   (presc),
        .tick    (tick)
    );

    always_comb begin
        rd_mux = '0;
        if (hit_now) begin
            case (idx_now)
                IDX_CTRL:     rd_mux = {{(32-CTRL_W){1'b0}}, ctrl};
                IDX_LOAD:     rd_mux = load;
                IDX_VALUE:    rd_mux = value;
                IDX_PRESCALE: rd_mux[PRESC_W-1:0] = presc;
                IDX_STATUS:   rd_mux[STATUS_IF] = if_flag;
                IDX_ID:       rd_mux = ID_VALUE;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend    <= 1'b0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            hit_q   <= 1'b0;
            wdata_q <= '0;
            prdata  <= '0;
        end else begin
            if (setup) begin
                pend    <= 1'b1;
                idx_q   <= idx_now;
                wr_q    <= pwrite;
                hit_q   <= hit_now;
                wdata_q <= pwdata;
            end else if (access) begin
                pend <= 1'b0;
            end
            prdata <= (setup && !pwrite) ? rd_mux : 32'd0;
        end
    end

`ifdef APB_TIMER_PSLVERR_EN
    logic err_now;
    assign err_now = !hit_now || !mapped_now ||
                     (pwrite && ((idx_now == IDX_VALUE) || (idx_now == IDX_ID)));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pslverr <= 1'b0;
        end else begin
            pslverr <= setup && err_now;
        end
    end
`else
    logic unused_mapped;
    assign unused_mapped = mapped_now;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ctrl    <= '0;
            load    <= '0;
            value   <= '0;
            presc   <= '0;
            if_flag <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= wdata_q[CTRL_W-1:0];
            end else if (expire && !ctrl[CTRL_PERIODIC]) begin
                ctrl[CTRL_EN] <= 1'b0;
            end

            if (wr_load) begin
                load <= wdata_q;
            end

            if (wr_load) begin
                value <= wdata_q;
            end else if (eff_tick) begin
                if (value != 32'd0) begin
                    value <= value - 32'd1;
                end else if (ctrl[CTRL_PERIODIC]) begin
                    value <= load;
                end
            end

            if (wr_presc) begin
                presc <= wdata_q[PRESC_W-1:0];
            end

            if (expire) begin
                if_flag <= 1'b1;
            end else if (wr_status && wdata_q[STATUS_IF]) begin
                if_flag <= 1'b0;
            end

            irq <= if_flag && ctrl[CTRL_IRQ_EN];
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: register map, periodic/one-shot timing, W1C collision, back-to-back access, reset.
// Builds with or without APB_TIMER_PSLVERR_EN.
module tb_apb_timer;

    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_LOAD  = 32'h04;
    localparam logic [31:0] A_VALUE = 32'h08;
    localparam logic [31:0] A_PRESC = 32'h0C;
    localparam logic [31:0] A_STAT  = 32'h10;
    localparam logic [31:0] A_ID    = 32'h14;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        irq;
`ifdef APB_TIMER_PSLVERR_EN
    logic        pslverr;
    logic        err_seen;
`endif

    int n_cmp = 0;
    int n_mis = 0;
    logic [31:0] rd;

    always #5 hclk = ~hclk;

    apb_timer dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
`ifdef APB_TIMER_PSLVERR_EN
        ,
        .pslverr (pslverr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Setup cycle, then access cycle with psel dropped and address/data scrambled.
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b1; pwrite = 1'b0; paddr = 32'hDEAD_BEEC; pwdata = 32'h5A5A_5A5A;
        @(posedge hclk); #1;
        penable = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr; pwdata = 32'h0;
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 32'hDEAD_BEEC;
        data = prdata;
`ifdef APB_TIMER_PSLVERR_EN
        err_seen = pslverr;
`endif
        @(posedge hclk); #1;
        penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_prdata", prdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;

        apb_read(A_CTRL, rd);  check("rst_ctrl", rd, 32'h0);
        apb_read(A_LOAD, rd);  check("rst_load", rd, 32'h0);
        apb_read(A_VALUE, rd); check("rst_value", rd, 32'h0);
        apb_read(A_PRESC, rd); check("rst_presc", rd, 32'h0);
        apb_read(A_STAT, rd);  check("rst_status", rd, 32'h0);
        apb_read(A_ID, rd);    check("rst_id", rd, 32'h5449_4D52);

        // Periodic, LOAD=5, PRESCALE=0: IF sets 6 edges after the CTRL commit (E0), then E12, E18.
        apb_write(A_LOAD, 32'd5);
        apb_write(A_PRESC, 32'd0);
        apb_write(A_CTRL, 32'h3);
        apb_read(A_STAT, rd);  check("per_stat_e0", rd, 32'h0);
        apb_read(A_VALUE, rd); check("per_value_e2", rd, 32'd3);
        apb_read(A_STAT, rd);  check("per_stat_e4", rd, 32'h0);
        apb_read(A_VALUE, rd); check("per_reload_e6", rd, 32'd5);
        apb_read(A_STAT, rd);  check("per_stat_e8", rd, 32'h1);
        apb_write(A_STAT, 32'h1);            // commits on E12, the next set edge
        apb_read(A_STAT, rd);  check("w1c_vs_set", rd, 32'h1);
        apb_write(A_STAT, 32'h1);            // commits on E16
        apb_read(A_STAT, rd);  check("per_clr_e16", rd, 32'h0);
        apb_read(A_STAT, rd);  check("per_recur_e18", rd, 32'h1);
        check("per_irq_masked", {31'd0, irq}, 32'h0);
        apb_write(A_CTRL, 32'h0);
        apb_write(A_STAT, 32'h1);
        apb_read(A_STAT, rd);  check("stop_stat", rd, 32'h0);

        // One-shot, LOAD=2, PRESCALE=3, IRQ_EN: IF at E12 after CTRL commit, irq at E13.
        apb_write(A_LOAD, 32'd2);
        apb_write(A_PRESC, 32'd3);
        apb_write(A_CTRL, 32'h5);
        apb_read(A_STAT, rd);  check("os_stat_e0", rd, 32'h0);
        repeat (8) @(posedge hclk);
        #1;
        apb_read(A_STAT, rd);  check("os_stat_e10", rd, 32'h0);
        check("os_irq_e12", {31'd0, irq}, 32'h0);
        @(posedge hclk); #1;
        check("os_irq_e13", {31'd0, irq}, 32'h1);
        apb_read(A_STAT, rd);  check("os_stat_set", rd, 32'h1);
        apb_read(A_CTRL, rd);  check("os_en_cleared", rd, 32'h4);
        apb_read(A_VALUE, rd); check("os_value_hold", rd, 32'h0);
        apb_write(A_STAT, 32'h1);
        check("os_irq_after_w1c", {31'd0, irq}, 32'h1);
        @(posedge hclk); #1;
        check("os_irq_drop", {31'd0, irq}, 32'h0);
        apb_read(A_STAT, rd);  check("os_stat_clr", rd, 32'h0);

        // Back-to-back write then read.
        apb_write(A_LOAD, 32'hA5A5_0001);
        apb_read(A_LOAD, rd);  check("b2b_load", rd, 32'hA5A5_0001);
        apb_read(A_VALUE, rd); check("b2b_value_copy", rd, 32'hA5A5_0001);
        apb_write(32'h0000_1004, 32'h0000_1234);
        apb_read(A_LOAD, rd);  check("miss_write_ignored", rd, 32'hA5A5_0001);

        // Unmapped offset and decode miss.
        apb_read(32'h0000_001C, rd); check("unmapped_rd", rd, 32'h0);
`ifdef APB_TIMER_PSLVERR_EN
        check("unmapped_err", {31'd0, err_seen}, 32'h1);
        check("unmapped_err_end", {31'd0, pslverr}, 32'h0);
`endif
        apb_read(32'h0000_1000, rd); check("miss_rd", rd, 32'h0);
`ifdef APB_TIMER_PSLVERR_EN
        check("miss_err", {31'd0, err_seen}, 32'h1);
        apb_read(A_CTRL, rd);
        check("ok_err", {31'd0, err_seen}, 32'h0);
        apb_write(A_ID, 32'h1);
        apb_read(A_ID, rd);
        check("id_after_write", rd, 32'h5449_4D52);
`endif
        check("prdata_idle", prdata, 32'h0);

        // Reset asserted during a read access cycle while the timer runs.
        apb_write(A_PRESC, 32'd0);
        apb_write(A_CTRL, 32'h7);
        repeat (3) @(posedge hclk);
        #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_LOAD;
        @(posedge hclk); #1;
        psel = 1'b0; penable = 1'b1;
        check("pre_rst_prdata", prdata, 32'hA5A5_0001);
        #2;
        hresetn = 1'b0;
        #1;
        check("rst_mid_prdata", prdata, 32'h0);
        check("rst_mid_irq", {31'd0, irq}, 32'h0);
        penable = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        check("post_rst_prdata", prdata, 32'h0);
        apb_read(A_CTRL, rd);  check("post_rst_ctrl", rd, 32'h0);
        apb_read(A_LOAD, rd);  check("post_rst_load", rd, 32'h0);
        apb_read(A_PRESC, rd); check("post_rst_presc", rd, 32'h0);
        repeat (5) @(posedge hclk);
        #1;
        apb_read(A_VALUE, rd); check("post_rst_value", rd, 32'h0);
        apb_read(A_STAT, rd);  check("post_rst_stat", rd, 32'h0);
        check("post_rst_irq", {31'd0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb_timer.md
# apb_timer

APB-side peripheral: 32-bit down-counting timer with 16-bit prescaler, auto-reload/one-shot modes and level interrupt. Sits directly downstream of the AHB-to-APB bridge on its `psel`/`penable`/`paddr`/`pwdata`/`prdata` bus, in the `hclk` domain. It is a zero-wait-state slave: there is no `pready`, and read data must be valid during the access cycle.

## Interface
- `BASE_ADDR`, 32'h0000_0000: 4 KB-aligned base. Access decodes when `paddr[31:12] == BASE_ADDR[31:12]`.
- `ID_VALUE`, 32'h5449_4D52: constant returned by the ID register.
- `PRESC_W`, 16: prescaler width.
- `hclk` in 1: clock.
- `hresetn` in 1: asynchronous, active-low reset.
- `psel` in 1: setup-phase select.
- `penable` in 1: access-phase strobe.
- `pwrite` in 1: write when 1. Valid in setup phase only.
- `paddr` in 32: byte address. Valid in setup phase only.
- `pwdata` in 32: write data. Valid in setup phase only.
- `prdata` out 32: read data, registered.
- `irq` out 1: interrupt, level-high, registered.

## Operation
- **Bus protocol.** The bridge drives `paddr`, `pwdata` and `pwrite` only in setup, and drops `psel` in the access cycle.
  - Setup phase: `psel=1`, `penable=0`. Latch `paddr[4:2]`, `pwrite`, `pwdata` and the decode hit. Set `pend=1`.
  - Access phase: `penable=1` with `pend=1`, regardless of `psel`. Commit the write if it is a write and hits. Clear `pend`.
  - `penable=1` with `pend=0` is ignored.
  - A new setup may follow an access immediately.
- **Register map** (offset, access, reset 0 unless stated):
  - 0x00 CTRL, RW: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN. Other bits read 0.
  - 0x04 LOAD, RW: 32-bit reload value. A write also copies the value into VALUE and zeroes the prescaler count.
  - 0x08 VALUE, RO.
  - 0x0C PRESCALE, RW: bits [PRESC_W-1:0].
  - 0x10 STATUS: bit0 IF. Write 1 to clear.
  - 0x14 ID, RO: returns ID_VALUE.
  - Other offsets, or a decode miss: reads return 0, writes are ignored.
- **Prescaler.** When EN=1, `pcnt` increments each `hclk`. When `pcnt==PRESCALE`, the block emits `tick` and sets `pcnt` to 0. A CTRL write that takes EN from 0 to 1 zeroes `pcnt`.
- **Counter, on `tick`:**
  - VALUE≠0: VALUE decrements.
  - VALUE==0: IF is set. With PERIODIC=1, VALUE reloads from LOAD. With PERIODIC=0, EN clears and VALUE holds 0.
- **Interrupt.** `irq` is the registered value of IF & IRQ_EN.
- **Simultaneous events:**
  - IF set and W1C in the same cycle: set wins.
  - LOAD write and `tick` in the same cycle: the write wins and the tick is discarded.
  - CTRL write and a one-shot EN auto-clear in the same cycle: the write wins.
- **Reset.** All registers, `pcnt`, `pend`, `prdata` and `irq` go to 0 asynchronously. A pending setup is dropped. A reset mid-count leaves the timer stopped.

## Timing
- **Read.** `prdata` is registered at the clock edge ending setup, so it is valid for the entire access cycle. Outside a read access cycle `prdata` is 0.
- **Write.** Register contents update at the clock edge ending the access cycle.
- **Period.** From the edge where EN=1 is written to IF=1: (PRESCALE+1)×(VALUE+1) cycles.
- **Interrupt latency.** `irq` rises 1 cycle after IF.
- **Wrap-around.** With PERIODIC=1, LOAD=N and PRESCALE=P, IF is set every (P+1)(N+1) cycles. LOAD=0 with PRESCALE=0 fires every cycle.

## Configuration
- `APB_TIMER_PSLVERR_EN` defined:
  - Adds output `pslverr` (1 bit, reset 0).
  - `pslverr` is asserted for the access cycle, registered like `prdata`, when the access misses decode, targets an unmapped offset, or writes VALUE or ID.
- Undefined: no `pslverr` port, and such accesses are silently ignored.

## Structure
- Package `apb_timer_pkg`:
  - register offset localparams;
  - CTRL bit indices (EN, PERIODIC, IRQ_EN);
  - STATUS IF index;
  - default ID_VALUE.
- One sub-module, `apb_timer_prescaler`:
  - inputs `en`, `clr`, `presc`;
  - output `tick`.
- Decode, the register bank and the counter live in the top level.

## Test plan
- Reset, then read every offset. Expect CTRL/LOAD/VALUE/PRESCALE/STATUS = 0, ID = 32'h5449_4D52, `irq`=0.
- Write LOAD=5, PRESCALE=0, CTRL=0x3. Expect IF after 6 cycles, VALUE reloads to 5, IF recurs every 6 cycles.
- One-shot: LOAD=2, PRESCALE=3, CTRL=0x5. Expect IF and `irq` after 12 cycles, CTRL.EN reads 0, VALUE stays 0.
- Write STATUS=1 on the same cycle IF sets. Expect IF=1. A second W1C clears IF, and `irq` drops 1 cycle later.
- Back-to-back setup/access with `psel` low during access. Write LOAD=0xA5A5_0001, then read it immediately: `prdata`=0xA5A5_0001 in the access cycle. Assert `hresetn` mid-count: all registers 0 and no stale `prdata`.
- Read offset 0x1C and an address outside BASE: `prdata`=0. With `APB_TIMER_PSLVERR_EN`, `pslverr`=1 for exactly that access cycle.
